pio_core: RTL and testbench
===========================

# pio_core

Programmable I/O block: four identical state machines share a 32-word program memory and drive a 32-bit GPIO bank, loosely modelled on RP2040 PIO. The host configures and feeds it through a one-command-per-cycle action bus (`action`/`index`/`mindex`/`din`) and reads results on `dout`. The block sits between the SoC host logic and the pad ring.

## Interface
- No parameters. 4 machines, 32 instruction words, 4-entry TX and RX FIFOs per machine.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `action` in 4: command code.
  - 0 NONE, 1 INSTR, 2 PEND, 3 PULL, 4 PUSH, 5 GRPS, 6 EN, 7 DIV.
  - 8 SIDES, 9 IMM, 10 APUSH, 11 APULL, 12 IPINS, 13 IDIRS, 14 ISRT, 15 OSRT.
- `index` in 5: program address for INSTR.
- `mindex` in 2: target machine for per-machine actions.
- `din` in 32: action payload.
- `dout` out 32: host read data.
- `gpio_in` in 32: pad inputs.
- `gpio_out` out 32: pad output values.
- `gpio_dir` out 32: pad directions, 1 = output.

## Operation
- Actions are sampled every rising `clk`.
- Action payloads (target machine `mindex` unless stated):
  - INSTR: `prog[index] <= din[15:0]`.
  - PEND: wrap_top `<= din[4:0]`, wrap_bottom `<= din[9:5]`.
  - PULL: pop this machine's RX FIFO into `dout`; `dout` = 0 if the FIFO is empty.
  - PUSH: write `din` into this machine's TX FIFO; dropped if full.
  - GRPS: pin control, RP2040 PINCTRL layout.
    - [31:29] sideset_count, [28:26] set_count, [25:20] out_count.
    - [19:15] in_base, [14:10] sideset_base, [9:5] set_base, [4:0] out_base.
  - EN: global enable mask, `din[3:0]`, bit n = machine n.
  - DIV: divider `din[23:0]`, 16.8 fixed point; values below 0x000100 are treated as 0x000100.
  - SIDES: `din[0]` = side-set optional (MSB of side field is its enable bit).
  - APUSH / APULL: `din[0]` = autopush / autopull enable, `din[5:1]` = threshold (0 means 32).
  - ISRT / OSRT: `din[0]` = 1 shift right, 0 shift left.
  - IPINS / IDIRS: load `gpio_out` / `gpio_dir` directly from `din`.
  - IMM: execute `din[15:0]` on the target machine immediately, regardless of enable or divider; delay field ignored; PC unchanged unless JMP/OUT PC/MOV PC.
- Clock divider: 24-bit accumulator per machine.
  - Each `clk`: acc += 0x100; when acc >= div, acc -= div and the machine ticks.
  - div = 0x000280 gives 2 ticks per 5 cycles.
- Instruction format: [15:13] opcode, [12:8] delay/side-set (side-set occupies the top sideset_count bits, delay the remainder).
  - JMP: conditions always, !X, X--, !Y, Y--, X!=Y, PIN (`gpio_in[in_base]`), !OSRE; target [4:0].
  - WAIT: GPIO source only; stall until `gpio_in[idx]` == pol. IRQ sources act as NOP.
  - IN: sources PINS, X, Y, NULL, ISR, OSR. Shifts bitcount (0 = 32) into ISR. Autopush fires when the count reaches the threshold.
  - OUT: destinations PINS, X, Y, NULL, PINDIRS, PC, ISR. Autopull fires when the count reaches the threshold.
  - PUSH / PULL: block bit [5]. Non-blocking PULL on empty copies X to OSR. Non-blocking PUSH on full drops the data.
  - MOV: destinations PINS, X, Y, PC, ISR, OSR. Sources PINS, X, Y, NULL, STATUS (=0), ISR, OSR. Ops none / invert / bit-reverse.
  - IRQ: NOP.
  - SET: PINS, X, Y, PINDIRS, 5-bit data, to set_count pins from set_base.
- PC advance: PC wraps from wrap_top to wrap_bottom, otherwise PC+1 mod 32.
- Delay: costs that many extra ticks after completion. Stalls do not consume delay.
- Side-set: applied on the instruction's first tick even if it stalls.
- Pin writes are masked to the group (base + count, wrapping mod 32).
- GPIO writes in the same cycle: a higher-numbered machine wins over a lower one; IPINS/IDIRS win over all.

## Timing
- Reset values:
  - Outputs: `gpio_out`, `gpio_dir`, `dout` = 0.
  - Program memory all 0; enable mask 0.
  - Per machine: wrap_top 31, wrap_bottom 0, div 0x000100, pinctrl 0, X/Y/ISR/OSR/PC = 0, ISR count 0, OSR count 32 (empty), FIFOs empty, acc 0.
- Reset may assert mid-operation; it clears all of the above asynchronously.
- Config actions take effect at the sampling edge; the new value is used from the next cycle.
- IMM executes at the sampling edge; its pin effects are visible on `gpio_out` immediately after that edge.
- Machine register/pin effects update on the tick edge.
- PULL-action data appears on `dout` after the sampling edge and holds until the next PULL.
- Disabled machine: fully frozen except IMM.
- Host PUSH and machine PULL in the same cycle on a full/empty FIFO: the FIFO count reflects both operations.

## Test plan
- Reset, then IMM 0xE001 (SET PINS,1) with GRPS 0x04000000 -> `gpio_out[0]` = 1 after that edge; other bits 0.
- Load 0xE001, 0xE000; PEND 1; DIV 0x000100; GRPS 0x04000000; EN 1 -> `gpio_out[0]` toggles every cycle.
- Same program, DIV 0x000200 -> toggles every 2 cycles; DIV 0x000280 -> 2 ticks per 5 cycles.
- PUSH 0xA5A5A5A5, program PULL block; MOV ISR,OSR; PUSH block -> host PULL returns 0xA5A5A5A5; a second PULL returns 0.
- SET X,3; loop JMP X-- with EN -> exactly 4 iterations, then falls through.
- WAIT 1 GPIO 5 with `gpio_in[5]`=0 -> PC stalls; drive 1 -> advances next tick.

Source files
------------

// File: rtl/pio_core.sv
// Programmable I/O block: four small state machines share a 32-word program memory
// and drive a 32-bit GPIO bank, configured and fed through a one-command action bus.
module pio_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  action,
    input  logic [4:0]  index,
    input  logic [1:0]  mindex,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_dir
);
    localparam logic [3:0] ActInstr = 4'd1, ActPend  = 4'd2, ActPull  = 4'd3, ActPush  = 4'd4;
    localparam logic [3:0] ActGrps  = 4'd5, ActEn    = 4'd6, ActDiv   = 4'd7, ActSides = 4'd8;
    localparam logic [3:0] ActImm   = 4'd9, ActApush = 4'd10, ActApull = 4'd11;
    localparam logic [3:0] ActIpins = 4'd12, ActIdirs = 4'd13, ActIsrt = 4'd14, ActOsrt = 4'd15;

    typedef struct packed {
        logic [4:0]       pc;
        logic [31:0]      x;
        logic [31:0]      y;
        logic [31:0]      isr;
        logic [31:0]      osr;
        logic [5:0]       isr_cnt;
        logic [5:0]       osr_cnt;
        logic [4:0]       wrap_top;
        logic [4:0]       wrap_bot;
        logic [23:0]      div;
        logic [23:0]      acc;
        logic [31:0]      pinctrl;
        logic             side_opt;
        logic             apush_en;
        logic             apull_en;
        logic             in_shr;
        logic             out_shr;
        logic             stall;
        logic [4:0]       apush_thr;
        logic [4:0]       apull_thr;
        logic [4:0]       delay;
        logic [3:0][31:0] tx_mem;
        logic [3:0][31:0] rx_mem;
        logic [1:0]       tx_rp;
        logic [1:0]       tx_wp;
        logic [1:0]       rx_rp;
        logic [1:0]       rx_wp;
        logic [2:0]       tx_cnt;
        logic [2:0]       rx_cnt;
    } sm_t;

    logic [15:0] prog_q [32];
    logic [15:0] prog_d [32];
    sm_t         sm_q   [4];
    sm_t         sm_d   [4];
    logic [3:0]  en_q, en_d;
    logic [31:0] dout_q, dout_d, gpio_out_q, gpio_out_d, gpio_dir_q, gpio_dir_d;

    function automatic sm_t sm_reset();
        sm_t r;
        r          = '0;
        r.wrap_top = 5'd31;
        r.div      = 24'h000100;
        r.osr_cnt  = 6'd32;
        r.in_shr   = 1'b1;
        r.out_shr  = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] low_mask(input logic [5:0] n);
        logic [32:0] m;
        m = (33'd1 << n) - 33'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] w;
        w = {v, v} << s;
        return w[63:32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] w;
        w = {v, v} >> s;
        return w[31:0];
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Replace only the pins of the group starting at base, wrapping mod 32.
    function automatic logic [31:0] pin_write(input logic [31:0] cur, input logic [31:0] val,
                                              input logic [4:0] base, input logic [5:0] cnt);
        logic [31:0] m;
        m = rotl(low_mask(cnt), base);
        return (cur & ~m) | (rotl(val, base) & m);
    endfunction

    always_comb begin
        sm_t         s, n;
        logic [15:0] instr;
        logic [2:0]  op, arg, ss_eff, dly_bits, side_n;
        logic [4:0]  field, low, delay_f, side_raw, jmp_tgt;
        logic [4:0]  in_base, side_base, set_base, out_base;
        logic [5:0]  nbits, out_cnt, push_thr, pull_thr;
        logic [6:0]  cnt_sum;
        logic [24:0] acc_sum;
        logic [31:0] dmask, src, out_data, rx_data;
        logic [63:0] w;
        logic        host_sel, imm, tick, run, stall, jump, side_en;
        logic        tx_pop, rx_push, tx_push_ok, rx_pop;

        prog_d     = prog_q;
        sm_d       = sm_q;
        en_d       = en_q;
        dout_d     = dout_q;
        gpio_out_d = gpio_out_q;
        gpio_dir_d = gpio_dir_q;

        for (int m = 0; m < 4; m++) begin
            s          = sm_q[m];
            n          = s;
            host_sel   = (mindex == m[1:0]);
            imm        = host_sel && (action == ActImm);
            tick       = 1'b0;
            stall      = 1'b0;
            jump       = 1'b0;
            jmp_tgt    = '0;
            tx_pop     = 1'b0;
            rx_push    = 1'b0;
            rx_data    = '0;
            src        = '0;
            out_data   = '0;
            w          = '0;
            cnt_sum    = '0;
            acc_sum    = '0;
            in_base    = s.pinctrl[19:15];
            side_base  = s.pinctrl[14:10];
            set_base   = s.pinctrl[9:5];
            out_base   = s.pinctrl[4:0];
            out_cnt    = (s.pinctrl[25:20] > 6'd32) ? 6'd32 : s.pinctrl[25:20];
            push_thr   = (s.apush_thr == 5'd0) ? 6'd32 : {1'b0, s.apush_thr};
            pull_thr   = (s.apull_thr == 5'd0) ? 6'd32 : {1'b0, s.apull_thr};

            if (en_q[m]) begin
                acc_sum = {1'b0, s.acc} + 25'h000100;
                if (acc_sum >= {1'b0, s.div}) begin
                    acc_sum = acc_sum - {1'b0, s.div};
                    tick    = 1'b1;
                end
                n.acc = acc_sum[23:0];
            end
            run = imm || (tick && (s.delay == 5'd0));
            if (tick && !imm && (s.delay != 5'd0)) n.delay = s.delay - 5'd1;

            instr    = imm ? din[15:0] : prog_q[s.pc];
            op       = instr[15:13];
            field    = instr[12:8];
            arg      = instr[7:5];
            low      = instr[4:0];
            nbits    = (low == 5'd0) ? 6'd32 : {1'b0, low};
            ss_eff   = (s.pinctrl[31:29] > 3'd5) ? 3'd5 : s.pinctrl[31:29];
            dly_bits = 3'd5 - ss_eff;
            dmask    = low_mask({3'b0, dly_bits});
            delay_f  = field & dmask[4:0];
            side_raw = field >> dly_bits;
            side_en  = 1'b0;
            side_n   = ss_eff;
            if (ss_eff != 3'd0) begin
                side_en = s.side_opt ? side_raw[ss_eff - 3'd1] : 1'b1;
                if (s.side_opt) side_n = ss_eff - 3'd1;
            end

            if (run) begin
                case (op)
                    3'd0: begin
                        case (arg)
                            3'd0: jump = 1'b1;
                            3'd1: jump = (s.x == '0);
                            3'd2: begin jump = (s.x != '0); n.x = s.x - 32'd1; end
                            3'd3: jump = (s.y == '0);
                            3'd4: begin jump = (s.y != '0); n.y = s.y - 32'd1; end
                            3'd5: jump = (s.x != s.y);
                            3'd6: jump = gpio_in[in_base];
                            default: jump = (s.osr_cnt < pull_thr);
                        endcase
                        jmp_tgt = low;
                    end
                    3'd1: if (arg[1:0] == 2'd0) stall = (gpio_in[low] != arg[2]);
                    3'd2: begin
                        case (arg)
                            3'd0:    src = rotr(gpio_in, in_base);
                            3'd1:    src = s.x;
                            3'd2:    src = s.y;
                            3'd6:    src = s.isr;
                            3'd7:    src = s.osr;
                            default: src = '0;
                        endcase
                        if (s.in_shr) begin
                            w     = {src, s.isr} >> nbits;
                            n.isr = w[31:0];
                        end else begin
                            w     = {32'h0, s.isr} << nbits;
                            n.isr = w[31:0] | (src & low_mask(nbits));
                        end
                        cnt_sum   = {1'b0, s.isr_cnt} + {1'b0, nbits};
                        n.isr_cnt = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
                        if (s.apush_en && (n.isr_cnt >= push_thr) && (s.rx_cnt != 3'd4)) begin
                            rx_push   = 1'b1;
                            rx_data   = n.isr;
                            n.isr     = '0;
                            n.isr_cnt = '0;
                        end
                    end
                    3'd3: begin
                        if (s.out_shr) begin
                            out_data = s.osr & low_mask(nbits);
                            w        = {32'h0, s.osr} >> nbits;
                        end else begin
                            w        = {32'h0, s.osr} << nbits;
                            out_data = w[63:32];
                        end
                        n.osr     = w[31:0];
                        cnt_sum   = {1'b0, s.osr_cnt} + {1'b0, nbits};
                        n.osr_cnt = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
                        case (arg)
                            3'd0: gpio_out_d = pin_write(gpio_out_d, out_data, out_base, out_cnt);
                            3'd1: n.x = out_data;
                            3'd2: n.y = out_data;
                            3'd4: gpio_dir_d = pin_write(gpio_dir_d, out_data, out_base, out_cnt);
                            3'd5: begin jump = 1'b1; jmp_tgt = out_data[4:0]; end
                            3'd6: begin n.isr = out_data; n.isr_cnt = nbits; end
                            default: ;
                        endcase
                        if (s.apull_en && (n.osr_cnt >= pull_thr) && (s.tx_cnt != 3'd0)) begin
                            tx_pop    = 1'b1;
                            n.osr     = s.tx_mem[s.tx_rp];
                            n.osr_cnt = '0;
                        end
                    end
                    3'd4: begin
                        if (instr[7]) begin
                            if (s.tx_cnt != 3'd0) begin
                                tx_pop    = 1'b1;
                                n.osr     = s.tx_mem[s.tx_rp];
                                n.osr_cnt = '0;
                            end else if (instr[5]) begin
                                stall = 1'b1;
                            end else begin
                                n.osr     = s.x;
                                n.osr_cnt = '0;
                            end
                        end else if ((s.rx_cnt == 3'd4) && instr[5]) begin
                            stall = 1'b1;
                        end else begin
                            // A non-blocking push into a full FIFO still empties the ISR.
                            rx_push   = (s.rx_cnt != 3'd4);
                            rx_data   = s.isr;
                            n.isr     = '0;
                            n.isr_cnt = '0;
                        end
                    end
                    3'd5: begin
                        case (instr[2:0])
                            3'd0:    src = rotr(gpio_in, in_base);
                            3'd1:    src = s.x;
                            3'd2:    src = s.y;
                            3'd6:    src = s.isr;
                            3'd7:    src = s.osr;
                            default: src = '0;
                        endcase
                        if (instr[4:3] == 2'd1) src = ~src;
                        else if (instr[4:3] == 2'd2) src = bit_rev(src);
                        case (arg)
                            3'd0: gpio_out_d = pin_write(gpio_out_d, src, out_base, out_cnt);
                            3'd1: n.x = src;
                            3'd2: n.y = src;
                            3'd5: begin jump = 1'b1; jmp_tgt = src[4:0]; end
                            3'd6: begin n.isr = src; n.isr_cnt = '0; end
                            3'd7: begin n.osr = src; n.osr_cnt = '0; end
                            default: ;
                        endcase
                    end
                    3'd6: ;
                    default: begin
                        case (arg)
                            3'd0: gpio_out_d = pin_write(gpio_out_d, {27'h0, low}, set_base,
                                                         {3'b0, s.pinctrl[28:26]});
                            3'd1: n.x = {27'h0, low};
                            3'd2: n.y = {27'h0, low};
                            3'd4: gpio_dir_d = pin_write(gpio_dir_d, {27'h0, low}, set_base,
                                                         {3'b0, s.pinctrl[28:26]});
                            default: ;
                        endcase
                    end
                endcase

                if (!stall) begin
                    if (jump) n.pc = jmp_tgt;
                    else if (!imm) n.pc = (s.pc == s.wrap_top) ? s.wrap_bot : s.pc + 5'd1;
                    if (!imm) n.delay = delay_f;
                end
                if (!imm) n.stall = stall;
                // Side-set goes out once, on the first tick of a (possibly stalling) instruction.
                if (side_en && (imm || !s.stall)) begin
                    gpio_out_d = pin_write(gpio_out_d, {27'h0, side_raw}, side_base, {3'b0, side_n});
                end
            end

            if (host_sel) begin
                case (action)
                    ActPend:  begin n.wrap_top = din[4:0]; n.wrap_bot = din[9:5]; end
                    ActGrps:  n.pinctrl = din;
                    ActDiv:   n.div = (din[23:0] < 24'h000100) ? 24'h000100 : din[23:0];
                    ActSides: n.side_opt = din[0];
                    ActApush: begin n.apush_en = din[0]; n.apush_thr = din[5:1]; end
                    ActApull: begin n.apull_en = din[0]; n.apull_thr = din[5:1]; end
                    ActIsrt:  n.in_shr = din[0];
                    ActOsrt:  n.out_shr = din[0];
                    default:  ;
                endcase
            end

            // A simultaneous machine pop lets a host push into a full TX FIFO succeed.
            tx_push_ok = host_sel && (action == ActPush) && ((s.tx_cnt != 3'd4) || tx_pop);
            if (tx_pop) n.tx_rp = s.tx_rp + 2'd1;
            if (tx_push_ok) begin
                n.tx_mem[s.tx_wp] = din;
                n.tx_wp           = s.tx_wp + 2'd1;
            end
            n.tx_cnt = s.tx_cnt + {2'b0, tx_push_ok} - {2'b0, tx_pop};

            rx_pop = host_sel && (action == ActPull) && (s.rx_cnt != 3'd0);
            if (host_sel && (action == ActPull)) dout_d = rx_pop ? s.rx_mem[s.rx_rp] : '0;
            if (rx_pop) n.rx_rp = s.rx_rp + 2'd1;
            if (rx_push) begin
                n.rx_mem[s.rx_wp] = rx_data;
                n.rx_wp           = s.rx_wp + 2'd1;
            end
            n.rx_cnt = s.rx_cnt + {2'b0, rx_push} - {2'b0, rx_pop};

            sm_d[m] = n;
        end

        case (action)
            ActInstr: prog_d[index] = din[15:0];
            ActEn:    en_d = din[3:0];
            ActIpins: gpio_out_d = din;
            ActIdirs: gpio_dir_d = din;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) prog_q[i] <= '0;
            for (int m = 0; m < 4; m++) sm_q[m] <= sm_reset();
            en_q       <= '0;
            dout_q     <= '0;
            gpio_out_q <= '0;
            gpio_dir_q <= '0;
        end else begin
            prog_q     <= prog_d;
            sm_q       <= sm_d;
            en_q       <= en_d;
            dout_q     <= dout_d;
            gpio_out_q <= gpio_out_d;
            gpio_dir_q <= gpio_dir_d;
        end
    end

    assign dout     = dout_q;
    assign gpio_out = gpio_out_q;
    assign gpio_dir = gpio_dir_q;

endmodule

// File: tb/tb_pio_core.sv
// Directed bench for pio_core: expected values go into a scoreboard queue as stimulus
// is applied and are popped and compared once the DUT output is due.
module tb_pio_core;
    localparam logic [3:0] AInstr = 4'd1, APend = 4'd2, APull = 4'd3, APush = 4'd4;
    localparam logic [3:0] AGrps = 4'd5, AEn = 4'd6, ADiv = 4'd7, AImm = 4'd9;
    localparam logic [3:0] AIpins = 4'd12, AIdirs = 4'd13;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din, dout, gpio_in, gpio_out, gpio_dir;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    pio_core dut (
        .clk      (clk),
        .reset    (reset),
        .action   (action),
        .index    (index),
        .mindex   (mindex),
        .din      (din),
        .dout     (dout),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_dir (gpio_dir)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic act(input logic [3:0] a, input logic [4:0] i, input logic [1:0] m,
                       input logic [31:0] d);
        action = a;
        index  = i;
        mindex = m;
        din    = d;
        cycles(1);
        action = 4'd0;
        din    = '0;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h, required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(1);
    endtask

    // Two-instruction toggle loop on pin 0; counts pin changes over 20 cycles.
    task automatic toggle_run(input logic [23:0] dv, input int exp_toggles, input string tag);
        int   t;
        logic prev;
        t = 0;
        do_reset();
        act(AInstr, 5'd0, 2'd0, 32'hE001);
        act(AInstr, 5'd1, 2'd0, 32'hE000);
        act(APend, 5'd0, 2'd0, 32'd1);
        act(ADiv, 5'd0, 2'd0, {8'h0, dv});
        act(AGrps, 5'd0, 2'd0, 32'h0400_0000);
        expect_val(tag, exp_toggles);
        act(AEn, 5'd0, 2'd0, 32'd1);
        prev = gpio_out[0];
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (gpio_out[0] != prev) t++;
            prev = gpio_out[0];
        end
        check(t);
    endtask

    task automatic load_fifo_prog();
        act(AInstr, 5'd0, 2'd0, 32'h80A0);  // PULL block
        act(AInstr, 5'd1, 2'd0, 32'hA0C7);  // MOV ISR, OSR
        act(AInstr, 5'd2, 2'd0, 32'h8020);  // PUSH block
    endtask

    initial begin
        int rises;
        logic prev;
        action  = 4'd0;
        index   = '0;
        mindex  = '0;
        din     = '0;
        gpio_in = '0;
        reset   = 1'b1;
        #2;
        do_reset();

        expect_val("reset_gpio_out", 32'h0);
        check(gpio_out);
        expect_val("reset_gpio_dir", 32'h0);
        check(gpio_dir);
        expect_val("reset_dout", 32'h0);
        check(dout);

        act(AGrps, 5'd0, 2'd0, 32'h0400_0000);
        expect_val("imm_set_pins", 32'h0000_0001);
        act(AImm, 5'd0, 2'd0, 32'hE001);
        check(gpio_out);

        act(AGrps, 5'd0, 2'd1, 32'h2000_0C00);
        expect_val("imm_sideset_pin3", 32'h0000_0009);
        act(AImm, 5'd0, 2'd1, 32'hD000);
        check(gpio_out);

        expect_val("ipins", 32'hDEAD_BEEF);
        act(AIpins, 5'd0, 2'd0, 32'hDEAD_BEEF);
        check(gpio_out);
        expect_val("idirs", 32'h0000_FFFF);
        act(AIdirs, 5'd0, 2'd0, 32'h0000_FFFF);
        check(gpio_dir);

        toggle_run(24'h000100, 20, "div_100_toggles");
        toggle_run(24'h000200, 10, "div_200_toggles");
        toggle_run(24'h000280, 8, "div_280_toggles");

        do_reset();
        load_fifo_prog();
        act(APush, 5'd0, 2'd0, 32'hA5A5_A5A5);
        act(AEn, 5'd0, 2'd0, 32'd1);
        cycles(12);
        expect_val("pull_a5", 32'hA5A5_A5A5);
        act(APull, 5'd0, 2'd0, 32'h0);
        check(dout);
        expect_val("pull_empty", 32'h0);
        act(APull, 5'd0, 2'd0, 32'h0);
        check(dout);

        // Five host pushes into a four-deep TX FIFO: the last one is dropped.
        do_reset();
        load_fifo_prog();
        for (int k = 1; k <= 5; k++) act(APush, 5'd0, 2'd0, 32'h1111_1111 * k);
        act(AEn, 5'd0, 2'd0, 32'd1);
        cycles(40);
        for (int k = 1; k <= 4; k++) begin
            expect_val($sformatf("depth_pull_%0d", k), 32'h1111_1111 * k);
            act(APull, 5'd0, 2'd0, 32'h0);
            check(dout);
        end
        expect_val("depth_pull_dropped", 32'h0);
        act(APull, 5'd0, 2'd0, 32'h0);
        check(dout);

        do_reset();
        act(AInstr, 5'd0, 2'd0, 32'hE023);  // SET X, 3
        act(AInstr, 5'd1, 2'd0, 32'hE001);  // SET PINS, 1
        act(AInstr, 5'd2, 2'd0, 32'hE000);  // SET PINS, 0
        act(AInstr, 5'd3, 2'd0, 32'h0041);  // JMP X-- 1
        act(AInstr, 5'd4, 2'd0, 32'hE081);  // SET PINDIRS, 1
        act(AInstr, 5'd5, 2'd0, 32'h0005);  // JMP 5
        act(AGrps, 5'd0, 2'd0, 32'h0400_0000);
        expect_val("jmp_xdec_iterations", 32'd4);
        expect_val("jmp_fallthrough_dir", 32'h0000_0001);
        act(AEn, 5'd0, 2'd0, 32'd1);
        rises = 0;
        prev  = gpio_out[0];
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (gpio_out[0] && !prev) rises++;
            prev = gpio_out[0];
        end
        check(rises);
        check(gpio_dir);

        // Asynchronous reset between clock edges clears the outputs at once.
        #2;
        reset = 1'b0;
        #1;
        expect_val("async_reset_dir", 32'h0);
        check(gpio_dir);
        expect_val("async_reset_out", 32'h0);
        check(gpio_out);
        cycles(1);
        reset = 1'b1;
        cycles(1);

        gpio_in = '0;
        act(AInstr, 5'd0, 2'd0, 32'h2085);  // WAIT 1 GPIO 5
        act(AInstr, 5'd1, 2'd0, 32'hE001);  // SET PINS, 1
        act(AInstr, 5'd2, 2'd0, 32'h0002);  // JMP 2
        act(AGrps, 5'd0, 2'd0, 32'h0400_0000);
        act(AEn, 5'd0, 2'd0, 32'd1);
        cycles(10);
        expect_val("wait_stalled", 32'h0);
        check(gpio_out);
        gpio_in[5] = 1'b1;
        cycles(1);
        expect_val("wait_release_edge", 32'h0);
        check(gpio_out);
        cycles(1);
        expect_val("wait_advanced", 32'h0000_0001);
        check(gpio_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
